// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampling UART receiver. Recovers start / 8 data (LSB
//                first) / optional parity / stop frames using a 3-sample
//                majority vote around the bit centre. Reports the received
//                byte with a one-cycle data_valid pulse. Parity and framing
//                errors are reported as one-cycle pulses.
//                Optional macro UART_RX_SYNC_EN inserts a 2-flop input
//                synchronizer in front of the FSM (+2 CLK latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_CNT_W = $clog2(PRESCALE);
    localparam int c_BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    // Three sample points straddle the bit centre; the vote is taken on the last
    localparam logic [c_CNT_W-1:0] c_SAMP_A   = c_CNT_W'(PRESCALE / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_SAMP_B   = c_CNT_W'(PRESCALE / 2);
    localparam logic [c_CNT_W-1:0] c_SAMP_C   = c_CNT_W'(PRESCALE / 2 + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PRESCALE - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic                  w_rx;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;

    logic [c_CNT_W-1:0]    r_edge_cnt;
    logic [c_BIT_W-1:0]    r_bit_cnt;

    logic                  r_samp_a;
    logic                  r_samp_b;
    logic                  w_maj;
    logic                  w_at_decide;
    logic                  w_at_last;

    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_mismatch;
    logic                  w_par_expected;
    logic [DATA_WIDTH-1:0] r_shift;

    logic                  w_latch_cfg;
    logic                  w_shift_en;
    logic                  w_bit_adv;
    logic                  w_par_check;
    logic                  w_stop_decide;

    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_data_valid;
    logic                  r_par_err;
    logic                  r_stp_err;

    // ------------------------------------------------------------------
    // Serial input conditioning
    // ------------------------------------------------------------------
`ifdef UART_RX_SYNC_EN
    logic [1:0] r_sync;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], RX_IN};
        end
    end

    assign w_rx = r_sync[1];
`else
    assign w_rx = RX_IN;
`endif

    // ------------------------------------------------------------------
    // Sample-point decode and majority vote
    // ------------------------------------------------------------------
    assign w_at_decide = (r_edge_cnt == c_SAMP_C);
    assign w_at_last   = (r_edge_cnt == c_CNT_LAST);

    // Third sample is the live line value in the decision cycle
    assign w_maj = (r_samp_a & r_samp_b) | (r_samp_a & w_rx) | (r_samp_b & w_rx);

    // Expected parity bit: even parity makes the total ones count even
    assign w_par_expected = (^r_shift) ^ r_par_typ;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_rx) begin
                    w_next_state = c_ST_START;
                end
            end
            c_ST_START: begin
                // A high vote in the start bit is a line glitch, not a frame
                if (w_at_decide && w_maj) begin
                    w_next_state = c_ST_IDLE;
                end else if (w_at_last) begin
                    w_next_state = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_at_last && (r_bit_cnt == c_BIT_LAST)) begin
                    w_next_state = r_par_en ? c_ST_PARITY : c_ST_STOP;
                end
            end
            c_ST_PARITY: begin
                if (w_at_last) begin
                    w_next_state = c_ST_STOP;
                end
            end
            c_ST_STOP: begin
                // Leave mid-stop-bit so a following start edge is not missed
                if (w_at_decide) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Per-state datapath controls
    always_comb begin
        w_latch_cfg   = 1'b0;
        w_shift_en    = 1'b0;
        w_bit_adv     = 1'b0;
        w_par_check   = 1'b0;
        w_stop_decide = 1'b0;
        case (r_state)
            c_ST_START: begin
                w_latch_cfg = w_at_decide && !w_maj;
            end
            c_ST_DATA: begin
                w_shift_en = w_at_decide;
                w_bit_adv  = w_at_last;
            end
            c_ST_PARITY: begin
                w_par_check = w_at_decide;
            end
            c_ST_STOP: begin
                w_stop_decide = w_at_decide;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------

    // Oversample counter; the IDLE cycle that first sees the low line is
    // position 0 of the start bit, so START begins at position 1
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edge_cnt <= '0;
        end else if (r_state == c_ST_IDLE) begin
            r_edge_cnt <= w_rx ? '0 : c_CNT_ONE;
        end else if ((w_next_state == c_ST_IDLE) || w_at_last) begin
            r_edge_cnt <= '0;
        end else begin
            r_edge_cnt <= r_edge_cnt + c_CNT_ONE;
        end
    end

    // Data bit index, advanced at the end of each data bit
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_bit_cnt <= '0;
        end else if (r_state != c_ST_DATA) begin
            r_bit_cnt <= '0;
        end else if (w_bit_adv) begin
            r_bit_cnt <= (r_bit_cnt == c_BIT_LAST) ? '0 : r_bit_cnt + c_BIT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Capture the first two of the three majority samples
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_samp_a <= 1'b1;
            r_samp_b <= 1'b1;
        end else begin
            if (r_edge_cnt == c_SAMP_A) begin
                r_samp_a <= w_rx;
            end
            if (r_edge_cnt == c_SAMP_B) begin
                r_samp_b <= w_rx;
            end
        end
    end

    // Freeze the frame configuration once the start bit is confirmed
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
        end else if (w_latch_cfg) begin
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
        end
    end

    // Right shift: LSB arrives first and ends up in bit 0
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift <= '0;
        end else if (w_shift_en) begin
            r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
        end
    end

    // Parity mismatch flag; cleared per frame so parity-less frames never flag
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_par_mismatch <= 1'b0;
        end else if (w_latch_cfg) begin
            r_par_mismatch <= 1'b0;
        end else if (w_par_check) begin
            r_par_mismatch <= (w_maj != w_par_expected);
        end
    end

    // Registered result pulses, produced from the stop-bit decision
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
            if (w_stop_decide) begin
                r_stp_err <= !w_maj;
                r_par_err <= r_par_mismatch;
                if (w_maj && !r_par_mismatch) begin
                    r_data_valid <= 1'b1;
                    r_p_data     <= r_shift;
                end
            end
        end
    end

    assign P_DATA     = r_p_data;
    assign data_valid = r_data_valid;
    assign par_err    = r_par_err;
    assign stp_err    = r_stp_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. Directed vector table,
//                hand-written corner sequences and random frames checked
//                against a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int PRESCALE   = 8;
    localparam int DATA_WIDTH = 8;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       CLK_tb = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic       par_en;
    logic       par_typ;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    always #5 CLK_tb = ~CLK_tb;

    uart_rx #(
        .PRESCALE   (PRESCALE),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .CLK        (CLK_tb),
        .RST        (rst_n),
        .RX_IN      (rx_in),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .P_DATA     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    typedef struct {
        int         cyc;
        logic       valid;
        logic       perr;
        logic       serr;
        logic [7:0] data;
    } event_t;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic       pbit;
        logic       sbit;
        logic       exp_valid;
        logic       exp_perr;
        logic       exp_serr;
        logic [7:0] exp_data;
    } vec_t;

    event_t     obs_q[$];
    event_t     exp_q[$];
    event_t     mon_e;
    vec_t       vecs[6];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] model_data;
    int         c0;
    int         c1;

    // Cycle counter: number of rising edges so far
    always @(posedge CLK_tb) cyc <= cyc + 1;

    // Record every output pulse with the cycle it was seen in
    always @(negedge CLK_tb) begin
        if (data_valid || par_err || stp_err) begin
            mon_e.cyc   = cyc;
            mon_e.valid = data_valid;
            mon_e.perr  = par_err;
            mon_e.serr  = stp_err;
            mon_e.data  = p_data;
            obs_q.push_back(mon_e);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Falling edge of the start bit to the result pulse
    function automatic int lat(input logic pe);
        return (1 + DATA_WIDTH + (pe ? 1 : 0)) * PRESCALE + PRESCALE / 2 + 2 + SYNC_LAT;
    endfunction

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge CLK_tb);
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (PRESCALE) @(negedge CLK_tb);
    endtask

    // Drive one frame; configuration pins are scrambled after the start bit
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic pbit, input logic sbit, output int start);
        par_en  = pe;
        par_typ = pt;
        start   = cyc;
        drive_bit(1'b0);
        par_en  = 1'($urandom);
        par_typ = 1'($urandom);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pe) drive_bit(pbit);
        drive_bit(sbit);
    endtask

    task automatic push_exp(input int c, input logic v, input logic p, input logic s,
                            input logic [7:0] d);
        event_t e;
        e.cyc = c; e.valid = v; e.perr = p; e.serr = s; e.data = d;
        exp_q.push_back(e);
    endtask

    // Reference model: frame outcome from the line-format rules
    task automatic model_frame(input int start, input logic [7:0] d, input logic pe,
                               input logic pt, input logic pbit, input logic sbit);
        logic want_par;
        logic perr;
        logic ok;
        int   ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i] ? 1 : 0;
        want_par = ((ones % 2) == 1) ^ pt;
        perr     = pe && (pbit != want_par);
        ok       = sbit && !perr;
        if (ok) model_data = d;
        push_exp(start + lat(pe), ok, perr, !sbit, model_data);
    endtask

    // Match observed pulses to expected ones, in order
    task automatic verify(input string name);
        event_t e;
        event_t o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_missing: got no pulse, expected one at cycle %0d", name, e.cyc);
            end else begin
                o = obs_q.pop_front();
                check({name, "_cycle"}, o.cyc, e.cyc);
                check({name, "_valid"}, 32'(o.valid), 32'(e.valid));
                check({name, "_par_err"}, 32'(o.perr), 32'(e.perr));
                check({name, "_stp_err"}, 32'(o.serr), 32'(e.serr));
                check({name, "_p_data"}, 32'(o.data), 32'(e.data));
            end
        end
        check({name, "_extra_pulses"}, obs_q.size(), 0);
        obs_q.delete();
        check({name, "_p_data_hold"}, 32'(p_data), 32'(model_data));
    endtask

    initial begin
        // data  pe    pt    pbit  sbit  valid perr  serr  exp_data
        vecs[0] = '{8'hAB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hAB};
        vecs[1] = '{8'h48, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h48};
        vecs[2] = '{8'h48, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h48};
        vecs[3] = '{8'h48, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h48};
        vecs[4] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h48};
        vecs[5] = '{8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h48};

        model_data = 8'h00;
        rx_in   = 1'b1;
        par_en  = 1'b0;
        par_typ = 1'b0;
        rst_n   = 1'b0;

        // Reset state and quiet idle line
        repeat (3) @(negedge CLK_tb);
        check("reset_p_data", 32'(p_data), 32'h00);
        check("reset_data_valid", 32'(data_valid), 32'h0);
        check("reset_par_err", 32'(par_err), 32'h0);
        check("reset_stp_err", 32'(stp_err), 32'h0);
        rst_n = 1'b1;
        idle(100);
        verify("reset_idle");

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].pbit, vecs[i].sbit, c0);
            idle(12);
            push_exp(c0 + lat(vecs[i].pe), vecs[i].exp_valid, vecs[i].exp_perr,
                     vecs[i].exp_serr, vecs[i].exp_data);
            model_data = vecs[i].exp_data;
            verify($sformatf("vec%0d", i));
        end

        // Two-cycle glitch on an idle line, then a good frame proves IDLE
        rx_in = 1'b0;
        repeat (2) @(negedge CLK_tb);
        idle(30);
        verify("glitch");
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, c0);
        idle(12);
        model_frame(c0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        verify("after_glitch");

        // Continuous low: two framing errors, then the line rises in bit 4
        // of the third frame, which completes as 0xF0
        par_en = 1'b0;
        c0 = cyc;
        rx_in = 1'b0;
        repeat (196) @(negedge CLK_tb);
        idle(60);
        push_exp(c0 + lat(1'b0), 1'b0, 1'b0, 1'b1, model_data);
        push_exp(c0 + 2 * lat(1'b0), 1'b0, 1'b0, 1'b1, model_data);
        model_data = 8'hF0;
        push_exp(c0 + 3 * lat(1'b0), 1'b1, 1'b0, 1'b0, 8'hF0);
        verify("held_low");

        // Back-to-back frames, then reset in the middle of a third frame
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, c0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, c1);
        model_frame(c0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        model_frame(c1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge CLK_tb);
        check("midreset_p_data", 32'(p_data), 32'h00);
        check("midreset_data_valid", 32'(data_valid), 32'h0);
        check("midreset_stp_err", 32'(stp_err), 32'h0);
        rx_in = 1'b1;
        rst_n = 1'b1;
        idle(100);
        model_data = 8'h00;
        verify("b2b_reset");

        // Random frames against the reference model
        for (int n = 0; n < 25; n++) begin
            logic [7:0] d;
            logic       pe;
            logic       pt;
            logic       pbit;
            logic       sbit;
            int         ones;
            d    = 8'($urandom);
            pe   = 1'($urandom);
            pt   = 1'($urandom);
            sbit = ($urandom % 4) != 0;
            ones = 0;
            for (int i = 0; i < 8; i++) ones += d[i] ? 1 : 0;
            pbit = (((ones % 2) == 1) ^ pt) ^ (($urandom % 4) == 0);
            send_frame(d, pe, pt, pbit, sbit, c0);
            model_frame(c0, d, pe, pt, pbit, sbit);
            if (!sbit) idle(12);
            else idle($urandom_range(0, 10));
        end
        idle(20);
        verify("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver; downstream partner of the UART transmitter.
- Consumes the serial line format the transmitter emits: start bit 0, 8 data bits LSB first, optional parity bit, stop bit 1.
- Oversamples RX_IN at PRESCALE clocks per bit and recovers each bit by a 3-sample majority vote.
- Presents the recovered byte with a one-cycle valid pulse and reports parity and stop (framing) errors.

Parameters:
- PRESCALE, 8, CLK cycles per serial bit; must be even and >= 6.
- DATA_WIDTH, 8, data bits per frame.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- RX_IN  in  1  serial line; idles high.
- PAR_EN  in  1  1 = frame carries a parity bit.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- P_DATA  out  DATA_WIDTH  last correctly received byte.
- data_valid  out  1  one-cycle pulse when a new good byte is on P_DATA.
- par_err  out  1  one-cycle pulse when parity mismatches.
- stp_err  out  1  one-cycle pulse when the stop bit samples 0.

Behaviour:
- Reset (RST=0, asynchronous): FSM goes to IDLE and all counters clear. P_DATA=0, data_valid=0, par_err=0, stp_err=0.
- PAR_EN and PAR_TYP are latched when the start bit is confirmed. Changes mid-frame are ignored.
- Counters:
  - edge_cnt counts 0..PRESCALE-1 within a bit.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling: RX_IN is sampled at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1. The bit value is the majority of the three samples and is decided at PRESCALE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: RX_IN=0 in a cycle -> START, and edge_cnt=0 is loaded for that cycle.
  - START: if the majority value is 1, treat it as a glitch and return to IDLE (no error flagged). Otherwise -> DATA when edge_cnt=PRESCALE-1.
  - DATA: each bit is shifted into the MSB of the shift register, right shift, so the LSB arrives first. After bit DATA_WIDTH-1 reaches edge_cnt=PRESCALE-1 -> PARITY if PAR_EN, else STOP.
  - PARITY: compute expected = XOR of the data bits, inverted if PAR_TYP=1. Store mismatch = (sampled != expected). -> STOP at edge_cnt=PRESCALE-1.
  - STOP: the decision is made at edge_cnt=PRESCALE/2+1. The FSM then goes to IDLE on the next cycle, without waiting for the end of the bit, so back-to-back frames are accepted.
- Output timing: registered, asserted in the cycle after the stop-bit decision, high for exactly 1 CLK.
  - stop=1 and no parity mismatch: P_DATA is updated and data_valid=1.
  - parity mismatch: par_err=1, no data_valid, P_DATA unchanged.
  - stop=0: stp_err=1, no data_valid, P_DATA unchanged. par_err may pulse in the same cycle.
- Latency: from the RX_IN falling edge to data_valid is (1+DATA_WIDTH+PAR_EN)*PRESCALE + PRESCALE/2 + 2 CLK cycles. With the defaults and PAR_EN=0 this is 78.
- P_DATA is stable between data_valid pulses.
- RX_IN held low in IDLE:
  - Each frame completes and reports stp_err.
  - After a frame returns to IDLE it restarts only on a sampled 0, so a continuous low gives repeated stp_err frames.
- Reset asserted mid-frame aborts the frame immediately, with no pulses.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: RX_IN passes through a 2-flop synchronizer (both flops reset to 1) before the FSM. All latencies increase by 2 CLK.
- Undefined: RX_IN feeds the FSM directly and the source must be synchronous to CLK.

Test Plan:
- Reset: hold RST=0 for 3 cycles with RX_IN=1 -> P_DATA=8'h00, all pulses 0, no activity for 100 cycles after release.
- Frame 8'hAB, PAR_EN=0, PRESCALE=8 (each bit held 8 CLK) -> data_valid pulses once for 1 cycle, 78 CLK after the start edge (80 with UART_RX_SYNC_EN), P_DATA=8'hAB, par_err=stp_err=0.
- Frame 8'h48, PAR_EN=1, PAR_TYP=0, parity bit 0 -> P_DATA=8'h48 with data_valid. Same frame with parity bit 1 -> par_err pulse, no data_valid, P_DATA keeps 8'h48.
- Frame 8'h48, PAR_EN=1, PAR_TYP=1, parity bit 1 -> data_valid, P_DATA=8'h48.
- Frame 8'h01 with stop bit 0 -> stp_err pulse, no data_valid. Then a 2-cycle low glitch on an idle line -> no pulses, FSM back in IDLE.
- Back-to-back frames 8'h00 then 8'hFF with no idle gap -> two data_valid pulses with P_DATA=8'h00 then 8'hFF. Reset asserted during the data bits of a third frame -> no pulse, and outputs return to their reset values.
